// File: rtl/dct_mac_pkg.sv
// Shared width helpers and pipeline-stage control type for the fdct MAC.
package dct_mac_pkg;

    // Full-precision product width of an a*b pair.
    function automatic int prod_w(input int a_w, input int b_w);
        return a_w + b_w;
    endfunction

    // Accumulator width: product plus growth for num_terms sums plus a guard bit.
    function automatic int acc_w(input int a_w, input int b_w, input int num_terms);
        return a_w + b_w + $clog2(num_terms) + 1;
    endfunction

    // Term counter width: must represent 0..num_terms.
    function automatic int cnt_w(input int num_terms);
        return $clog2(num_terms + 1);
    endfunction

    // Control fields carried through S1/S2 beside the operand/product payload.
    typedef struct packed {
        logic vld;
        logic first;
    } stage_ctl_t;

endpackage

// File: rtl/dct_mac_round_sat.sv
// Combinational round-half-up, arithmetic right shift and saturation to OUT_W.
module dct_mac_round_sat #(
    parameter int ACC_W = 28,
    parameter int SHIFT = 8,
    parameter int OUT_W = 12
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [OUT_W-1:0] value,
    output logic                    ovf
);

    // One extra bit so adding the rounding bias can never wrap.
    localparam int EXT_W = ACC_W + 1;

    function automatic logic signed [EXT_W-1:0] round_half_up(input logic signed [ACC_W-1:0] x);
        logic signed [EXT_W-1:0] bias;
        bias = EXT_W'(1) <<< (SHIFT - 1);
        return (EXT_W'(x) + bias) >>> SHIFT;
    endfunction

    // Returns {clamped_flag, value}.
    function automatic logic [OUT_W:0] saturate(input logic signed [EXT_W-1:0] r);
        logic signed [EXT_W-1:0] hi;
        logic signed [EXT_W-1:0] lo;
        hi = (EXT_W'(1) <<< (OUT_W - 1)) - EXT_W'(1);
        lo = -(EXT_W'(1) <<< (OUT_W - 1));
        if (r > hi)      return {1'b1, hi[OUT_W-1:0]};
        else if (r < lo) return {1'b1, lo[OUT_W-1:0]};
        else             return {1'b0, r[OUT_W-1:0]};
    endfunction

    // Round the final sum, then clamp it into the output range.
    always_comb begin
        {ovf, value} = saturate(round_half_up(acc));
    end

endmodule

// File: rtl/dct_mac_pipe.sv
// Pipelined signed MAC: register operands, multiply, accumulate NUM_TERMS
// products, then round/saturate into a one-clock out_valid pulse.
module dct_mac_pipe
    import dct_mac_pkg::*;
#(
    parameter int A_W       = 8,
    parameter int B_W       = 16,
    parameter int NUM_TERMS = 8,
    parameter int SHIFT     = 8,
    parameter int OUT_W     = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic                    in_valid,
    input  logic                    first,
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] dout,
    output logic                    ovf,
    output logic                    abort
);

    localparam int PROD_W = prod_w(A_W, B_W);
    localparam int ACC_W  = acc_w(A_W, B_W, NUM_TERMS);
    localparam int CNT_W  = cnt_w(NUM_TERMS);

    logic signed [A_W-1:0]    a_p1;
    logic signed [B_W-1:0]    b_p1;
    stage_ctl_t               ctl_p1;
    logic signed [PROD_W-1:0] prod_p2;
    stage_ctl_t               ctl_p2;
    logic signed [ACC_W-1:0]  acc_p3;
    logic [CNT_W-1:0]         cnt_p3;
    logic                     done_p3;
    logic                     cap_p4;

    logic                     start;
    logic [CNT_W-1:0]         cnt_nxt;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [OUT_W-1:0]  rs_value;
    logic                     rs_ovf;

    // S1: capture operands and qualify first with in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_p1         <= '0;
            b_p1         <= '0;
            ctl_p1.vld   <= 1'b0;
            ctl_p1.first <= 1'b0;
        end else if (ena) begin
            a_p1         <= a;
            b_p1         <= b;
            ctl_p1.vld   <= in_valid;
            ctl_p1.first <= in_valid & first;
        end
    end

    // S2: registered full-precision product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_p2 <= '0;
            ctl_p2  <= '0;
        end else if (ena) begin
            prod_p2 <= PROD_W'(a_p1) * PROD_W'(b_p1);
            ctl_p2  <= ctl_p1;
        end
    end

    // A block starts on an explicit first or automatically after a completed block.
    always_comb begin
        start    = ctl_p2.first || (cnt_p3 == '0);
        cnt_nxt  = start ? CNT_W'(1) : cnt_p3 + CNT_W'(1);
        prod_ext = ACC_W'(prod_p2);
    end

    // S3: accumulate; flag done on the last term and wrap the counter to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_p3  <= '0;
            cnt_p3  <= '0;
            done_p3 <= 1'b0;
        end else if (ena) begin
            done_p3 <= 1'b0;
            if (ctl_p2.vld) begin
                acc_p3 <= start ? prod_ext : acc_p3 + prod_ext;
                if (cnt_nxt == CNT_W'(NUM_TERMS)) begin
                    cnt_p3  <= '0;
                    done_p3 <= 1'b1;
                end else begin
                    cnt_p3  <= cnt_nxt;
                end
            end
        end
    end

    // Early first inside a running block discards it; pulse lasts one clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) abort <= 1'b0;
        else        abort <= ena && ctl_p2.vld && ctl_p2.first && (cnt_p3 != '0);
    end

    dct_mac_round_sat #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) u_round_sat (
        .acc   (acc_p3),
        .value (rs_value),
        .ovf   (rs_ovf)
    );

    // S4: capture the rounded result; dout/ovf hold until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout   <= '0;
            ovf    <= 1'b0;
            cap_p4 <= 1'b0;
        end else begin
            cap_p4 <= ena && done_p3;
            if (ena && done_p3) begin
                dout <= rs_value;
                ovf  <= rs_ovf;
            end
        end
    end

    // out_valid follows the capture by one clock and drops regardless of ena.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_valid <= 1'b0;
        else        out_valid <= cap_p4;
    end

endmodule
